pipe_hazard_ctrl: RTL and testbench

- Hazard and stall sequencer for the 5-stage pipeline.
- Drives the write enable of the PC and IF/ID registers.
- Drives the bubble/flush controls that zero the ID/EX control bits (wreg, m2reg, wmem) and the IF/ID instruction.
- Generates the forwarding selects for ID-stage operands.
- Sequences a fixed-latency multiply/divide unit by holding the pipeline for its duration.

---
 rtl/pipe_hazard_ctrl.sv | 162 ++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
// ----------------
// Hazard and stall sequencer for the 5-stage pipeline. It decides each cycle
// whether the PC and IF/ID advance, whether ID/EX takes a bubble, and whether
// IF/ID is flushed. It also selects the forwarding source for both ID-stage
// operands and holds the pipeline while the fixed-latency mul/div unit runs.
//
// Parameters:
//   MD_LAT  cycles the mul/div unit needs after md_start (1..15)
//   CNT_W   width of the saturating stall-cycle counter
//
// Ports:
//   clk, clrn                  clock, synchronous active-high reset
//   id_rs, id_rt               source register fields of the ID instruction
//   id_use_rs, id_use_rt       ID instruction actually reads rs / rt
//   id_md                      ID instruction is a mul/div
//   ex_wreg, ex_m2reg, ex_rn   EX writeback enable, load flag, destination
//   mem_wreg, mem_m2reg, mem_rn  same for MEM
//   ex_br_taken                branch/jump resolved taken in EX
//   wpcir                      1 = PC and IF/ID advance
//   de_bubble                  1 = ID/EX captures zero control bits
//   ifid_flush                 1 = IF/ID captures a nop
//   fwda, fwdb                 forward selects (00 rf, 01 EX ALU, 10 MEM ALU, 11 MEM load)
//   md_start                   one-cycle start pulse to the mul/div unit
//   md_busy                    high while waiting on the mul/div unit
//   stall_cnt                  saturating count of cycles with wpcir=0
module pipe_hazard_ctrl #(
  parameter int MD_LAT = 4,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             id_md,
  input  logic             ex_wreg,
  input  logic             ex_m2reg,
  input  logic [4:0]       ex_rn,
  input  logic             mem_wreg,
  input  logic             mem_m2reg,
  input  logic [4:0]       mem_rn,
  input  logic             ex_br_taken,
  output logic             wpcir,
  output logic             de_bubble,
  output logic             ifid_flush,
  output logic [1:0]       fwda,
  output logic [1:0]       fwdb,
  output logic             md_start,
  output logic             md_busy,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic {RUN, MD_WAIT} state_t;

  localparam logic [3:0] MD_INIT = 4'(MD_LAT - 1);

  state_t     fsm, fsm_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       md_ok, md_ok_nxt;
  logic       lu;

  // Forward source for one operand register; the EX result is younger than
  // the MEM one, so an EX match wins. r0 is never forwarded.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] r,
    input logic       exw, exl,
    input logic [4:0] exn,
    input logic       mw, ml,
    input logic [4:0] mn
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (exw && !exl && exn != 5'd0 && exn == r)
      sel = 2'b01;
    else if (mw && !ml && mn != 5'd0 && mn == r)
      sel = 2'b10;
    else if (mw && ml && mn != 5'd0 && mn == r)
      sel = 2'b11;
    return sel;
  endfunction

  // Load-use: a load in EX has no data to forward yet, so a dependent ID
  // instruction must wait one cycle and then take the value from MEM.
  always_comb begin
    lu = ex_wreg && ex_m2reg && (ex_rn != 5'd0) &&
         ((id_use_rs && ex_rn == id_rs) || (id_use_rt && ex_rn == id_rt));
  end

  // Next-state and output decode. Reset forces a safe pipeline: nothing
  // advances and both ID/EX and IF/ID are cleared.
  always_comb begin
    fsm_nxt    = fsm;
    cnt_nxt    = cnt;
    md_ok_nxt  = md_ok;
    wpcir      = 1'b0;
    de_bubble  = 1'b1;
    ifid_flush = 1'b0;
    md_start   = 1'b0;
    md_busy    = 1'b0;
    fwda       = 2'b00;
    fwdb       = 2'b00;

    if (clrn) begin
      ifid_flush = 1'b1;
    end else begin
      fwda = fwd_sel(id_rs, ex_wreg, ex_m2reg, ex_rn, mem_wreg, mem_m2reg, mem_rn);
      fwdb = fwd_sel(id_rt, ex_wreg, ex_m2reg, ex_rn, mem_wreg, mem_m2reg, mem_rn);
      case (fsm)
        RUN: begin
          if (ex_br_taken) begin
            // Wrong-path instructions in IF and ID are squashed
            wpcir      = 1'b1;
            ifid_flush = 1'b1;
            md_ok_nxt  = 1'b0;
          end else if (lu) begin
            wpcir = 1'b0;
          end else if (id_md && !md_ok) begin
            // md_ok remembers a finished operation so the held mul/div
            // instruction leaves ID instead of starting again
            md_start = 1'b1;
            fsm_nxt  = MD_WAIT;
            cnt_nxt  = MD_INIT;
          end else begin
            wpcir     = 1'b1;
            de_bubble = 1'b0;
            md_ok_nxt = 1'b0;
          end
        end
        MD_WAIT: begin
          // A taken branch cannot reach EX here since EX holds a bubble
          md_busy = 1'b1;
          if (cnt == 4'd0) begin
            fsm_nxt   = RUN;
            md_ok_nxt = 1'b1;
          end else begin
            cnt_nxt = cnt - 4'd1;
          end
        end
        default: fsm_nxt = RUN;
      endcase
    end
  end

  // State registers and the saturating stall counter
  always_ff @(posedge clk) begin
    if (clrn) begin
      fsm       <= RUN;
      cnt       <= 4'd0;
      md_ok     <= 1'b0;
      stall_cnt <= '0;
    end else begin
      fsm   <= fsm_nxt;
      cnt   <= cnt_nxt;
      md_ok <= md_ok_nxt;
      if (!wpcir && stall_cnt != {CNT_W{1'b1}})
        stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl
// -------------------
// Drives directed scenarios followed by random traffic into two copies of
// pipe_hazard_ctrl (16-bit and 4-bit stall counters) and compares every
// output each cycle against a behavioural model of the hazard rules.
module tb_pipe_hazard_ctrl;

  localparam int MD_LAT = 4;

  typedef struct {
    logic       clrn;
    logic [4:0] id_rs, id_rt;
    logic       id_use_rs, id_use_rt, id_md;
    logic       ex_wreg, ex_m2reg;
    logic [4:0] ex_rn;
    logic       mem_wreg, mem_m2reg;
    logic [4:0] mem_rn;
    logic       ex_br_taken;
  } stim_t;

  logic        clk = 1'b0;
  logic        clrn;
  logic [4:0]  id_rs, id_rt, ex_rn, mem_rn;
  logic        id_use_rs, id_use_rt, id_md;
  logic        ex_wreg, ex_m2reg, mem_wreg, mem_m2reg, ex_br_taken;
  logic        wpcir, de_bubble, ifid_flush, md_start, md_busy;
  logic [1:0]  fwda, fwdb;
  logic [15:0] stall_cnt;
  logic        wpcir4, de_bubble4, ifid_flush4, md_start4, md_busy4;
  logic [1:0]  fwda4, fwdb4;
  logic [3:0]  stall_cnt4;

  int checks = 0;
  int failures = 0;
  int cycle = 0;

  // Model state: remaining mul/div wait cycles, finished-op flag, stalls seen
  int waitLeft = 0;
  bit mdDone = 0;
  int stalls = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MD_LAT(MD_LAT), .CNT_W(16)) dut (
    .clk(clk), .clrn(clrn), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_md(id_md),
    .ex_wreg(ex_wreg), .ex_m2reg(ex_m2reg), .ex_rn(ex_rn),
    .mem_wreg(mem_wreg), .mem_m2reg(mem_m2reg), .mem_rn(mem_rn),
    .ex_br_taken(ex_br_taken), .wpcir(wpcir), .de_bubble(de_bubble),
    .ifid_flush(ifid_flush), .fwda(fwda), .fwdb(fwdb),
    .md_start(md_start), .md_busy(md_busy), .stall_cnt(stall_cnt)
  );

  pipe_hazard_ctrl #(.MD_LAT(MD_LAT), .CNT_W(4)) dut4 (
    .clk(clk), .clrn(clrn), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_md(id_md),
    .ex_wreg(ex_wreg), .ex_m2reg(ex_m2reg), .ex_rn(ex_rn),
    .mem_wreg(mem_wreg), .mem_m2reg(mem_m2reg), .mem_rn(mem_rn),
    .ex_br_taken(ex_br_taken), .wpcir(wpcir4), .de_bubble(de_bubble4),
    .ifid_flush(ifid_flush4), .fwda(fwda4), .fwdb(fwdb4),
    .md_start(md_start4), .md_busy(md_busy4), .stall_cnt(stall_cnt4)
  );

  // A taken branch while the mul/div unit is busy is an illegal input
  always @(posedge clk) begin
    if (!clrn)
      assert (!(md_busy && ex_br_taken)) else $error("[TB] branch taken during mul/div wait");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s cycle=%0d got=%0h expected=%0h", tag, cycle, obs, exp);
    end
  endtask

  function automatic stim_t idle();
    stim_t s;
    s.clrn = 1'b0; s.id_rs = '0; s.id_rt = '0; s.id_use_rs = 1'b0; s.id_use_rt = 1'b0;
    s.id_md = 1'b0; s.ex_wreg = 1'b0; s.ex_m2reg = 1'b0; s.ex_rn = '0;
    s.mem_wreg = 1'b0; s.mem_m2reg = 1'b0; s.mem_rn = '0; s.ex_br_taken = 1'b0;
    return s;
  endfunction

  function automatic logic [1:0] refFwd(input stim_t s, input logic [4:0] r);
    if (r == 0) return 2'b00;
    if (s.ex_wreg && !s.ex_m2reg && s.ex_rn == r) return 2'b01;
    if (s.mem_wreg && s.mem_rn == r) return s.mem_m2reg ? 2'b11 : 2'b10;
    return 2'b00;
  endfunction

  // Drive one cycle of inputs, check all outputs mid-cycle, advance the model
  task automatic applyStimulus(input stim_t s);
    logic [1:0] eA, eB;
    logic eW, eBub, eFl, eSt, eBusy, loadUse;
    int eCnt4;
    @(negedge clk);
    clrn = s.clrn; id_rs = s.id_rs; id_rt = s.id_rt;
    id_use_rs = s.id_use_rs; id_use_rt = s.id_use_rt; id_md = s.id_md;
    ex_wreg = s.ex_wreg; ex_m2reg = s.ex_m2reg; ex_rn = s.ex_rn;
    mem_wreg = s.mem_wreg; mem_m2reg = s.mem_m2reg; mem_rn = s.mem_rn;
    ex_br_taken = s.ex_br_taken;
    #1;
    loadUse = s.ex_wreg && s.ex_m2reg && s.ex_rn != 0 &&
              ((s.id_use_rs && s.ex_rn == s.id_rs) || (s.id_use_rt && s.ex_rn == s.id_rt));
    eA = refFwd(s, s.id_rs); eB = refFwd(s, s.id_rt);
    eW = 0; eBub = 1; eFl = 0; eSt = 0; eBusy = 0;
    if (s.clrn) begin
      eFl = 1; eA = 0; eB = 0;
    end else if (waitLeft > 0) begin
      eBusy = 1;
    end else if (s.ex_br_taken) begin
      eW = 1; eFl = 1;
    end else if (loadUse) begin
      eW = 0;
    end else if (s.id_md && !mdDone) begin
      eSt = 1;
    end else begin
      eW = 1; eBub = 0;
    end
    eCnt4 = (stalls > 15) ? 15 : stalls;
    checkOutput("wpcir", 32'(wpcir), 32'(eW));
    checkOutput("de_bubble", 32'(de_bubble), 32'(eBub));
    checkOutput("ifid_flush", 32'(ifid_flush), 32'(eFl));
    checkOutput("md_start", 32'(md_start), 32'(eSt));
    checkOutput("md_busy", 32'(md_busy), 32'(eBusy));
    checkOutput("fwda", 32'(fwda), 32'(eA));
    checkOutput("fwdb", 32'(fwdb), 32'(eB));
    checkOutput("stall_cnt", 32'(stall_cnt), 32'(stalls));
    checkOutput("stall_cnt4", 32'(stall_cnt4), 32'(eCnt4));
    checkOutput("wpcir4", 32'(wpcir4), 32'(eW));
    @(posedge clk);
    cycle++;
    if (s.clrn) begin
      waitLeft = 0; mdDone = 0; stalls = 0;
    end else begin
      if (!eW) stalls++;
      if (waitLeft > 0) begin
        waitLeft--;
        if (waitLeft == 0) mdDone = 1;
      end else if (s.ex_br_taken) mdDone = 0;
      else if (eSt) waitLeft = MD_LAT;
      else if (eW) mdDone = 0;
    end
  endtask

  initial begin
    stim_t s;
    $display("[TB] start");

    // Reset, then start a mul/div and reset in the middle of its wait
    s = idle(); s.clrn = 1;
    repeat (2) applyStimulus(s);
    s = idle(); s.id_md = 1;
    repeat (3) applyStimulus(s);
    s.clrn = 1;
    repeat (2) applyStimulus(s);
    s = idle();
    applyStimulus(s);

    // Full mul/div: start, MD_LAT wait cycles, then the op advances
    s = idle(); s.id_md = 1;
    repeat (MD_LAT + 2) applyStimulus(s);
    s = idle();
    applyStimulus(s);

    // Forwarding priority and r0 exclusion
    s = idle(); s.id_rs = 5; s.id_rt = 5; s.id_use_rs = 1; s.id_use_rt = 1;
    s.ex_wreg = 1; s.ex_rn = 5; s.mem_wreg = 1; s.mem_m2reg = 1; s.mem_rn = 5;
    applyStimulus(s);
    s.ex_rn = 0;
    applyStimulus(s);
    s.ex_rn = 5; s.id_rs = 0; s.id_rt = 0;
    applyStimulus(s);

    // Load-use on rt, then the load reaches MEM
    s = idle(); s.id_rt = 3; s.id_use_rt = 1; s.ex_wreg = 1; s.ex_m2reg = 1; s.ex_rn = 3;
    applyStimulus(s);
    s.ex_wreg = 0; s.ex_m2reg = 0; s.ex_rn = 0; s.mem_wreg = 1; s.mem_m2reg = 1; s.mem_rn = 3;
    applyStimulus(s);

    // Branch outranks load-use and mul/div
    s = idle(); s.id_rs = 7; s.id_use_rs = 1; s.ex_wreg = 1; s.ex_m2reg = 1; s.ex_rn = 7;
    s.id_md = 1; s.ex_br_taken = 1;
    applyStimulus(s);

    // Load-use ahead of a mul/div: stall first, then start
    s.ex_br_taken = 0;
    applyStimulus(s);
    s = idle(); s.id_md = 1;
    repeat (MD_LAT + 2) applyStimulus(s);

    // Saturation of the narrow counter after a fresh reset
    s = idle(); s.clrn = 1;
    applyStimulus(s);
    s = idle(); s.id_rs = 2; s.id_use_rs = 1; s.ex_wreg = 1; s.ex_m2reg = 1; s.ex_rn = 2;
    repeat (20) applyStimulus(s);

    // Random traffic; branches only when the model says EX can hold one
    for (int i = 0; i < 3000; i++) begin
      s.clrn = ($urandom_range(0, 63) == 0);
      s.id_rs = 5'($urandom_range(0, 3)); s.id_rt = 5'($urandom_range(0, 3));
      s.id_use_rs = 1'($urandom); s.id_use_rt = 1'($urandom);
      s.id_md = ($urandom_range(0, 3) == 0);
      s.ex_wreg = 1'($urandom); s.ex_m2reg = 1'($urandom); s.ex_rn = 5'($urandom_range(0, 3));
      s.mem_wreg = 1'($urandom); s.mem_m2reg = 1'($urandom); s.mem_rn = 5'($urandom_range(0, 3));
      s.ex_br_taken = (waitLeft == 0) && ($urandom_range(0, 7) == 0);
      applyStimulus(s);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
